// File: rtl/inst_fetch.sv
// CPU32 instruction fetch: owns the PC, issues single-outstanding imem reads and
// buffers returned words in a 2-entry queue for the decoder.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StWait, StDrain, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] q_pc_q   [2];
  logic [31:0] q_pc_d   [2];
  logic [31:0] q_word_q [2];
  logic [31:0] q_word_d [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        halt_pend_q, halt_pend_d;

  logic        pop;
  logic        req_start;
  logic        flush;
  logic        push;
  logic        do_pop;
  logic        tail;
  logic [31:0] redirect_tgt;

  assign tail         = head_q ^ count_q[0];
  assign redirect_tgt = redirect_pc & ~32'd3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      q_pc_q      <= '{default: '0};
      q_word_q    <= '{default: '0};
      head_q      <= 1'b0;
      count_q     <= 2'd0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      q_pc_q      <= q_pc_d;
      q_word_q    <= q_word_d;
      head_q      <= head_d;
      count_q     <= count_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    q_pc_d      = q_pc_q;
    q_word_d    = q_word_q;
    head_d      = head_q;
    count_d     = count_q;
    halt_pend_d = halt_pend_q;
    flush       = 1'b0;
    push        = 1'b0;
    do_pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (halt) begin
          flush   = 1'b1;
          state_d = StHalt;
        end else if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_tgt;
        end else begin
          do_pop = pop;
          if (req_start) begin
            state_d    = StWait;
            req_addr_d = fetch_pc_q;
          end
        end
      end
      StWait: begin
        // An ack landing with a halt/redirect closes the transaction; its data is dropped.
        if (halt) begin
          flush       = 1'b1;
          halt_pend_d = 1'b1;
          state_d     = imem_ack ? StHalt : StDrain;
        end else if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_tgt;
          state_d    = imem_ack ? StIdle : StDrain;
        end else begin
          do_pop = pop;
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = StIdle;
          end
        end
      end
      StDrain: begin
        if (halt || halt_pend_q) begin
          flush       = 1'b1;
          halt_pend_d = 1'b1;
          if (imem_ack) state_d = StHalt;
        end else if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_tgt;
          if (imem_ack) state_d = StIdle;
        end else begin
          do_pop = pop;
          if (imem_ack) state_d = StIdle;
        end
      end
      default: flush = 1'b1;
    endcase

    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (push) begin
        q_pc_d[tail]   = fetch_pc_q;
        q_word_d[tail] = imem_rdata;
      end
      head_d  = head_q ^ do_pop;
      count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  always_comb begin
    inst_valid = (count_q != 2'd0) && (state_q != StHalt);
    inst       = q_word_q[head_q];
    inst_pc    = q_pc_q[head_q];
    halted     = (state_q == StHalt);
    pop        = inst_valid && inst_ready;
    req_start  = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc_q;
    unique case (state_q)
      StIdle: begin
        // A pop in this cycle frees the reserved slot, so a full queue may still issue.
        req_start = !reset && !halt && !redirect && ((count_q < 2'd2) || pop);
        imem_req  = req_start;
      end
      StWait, StDrain: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, corner sequences,
// and randomized traffic against an instruction-stream reference model.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_ready;
  logic        redirect, halt, halted;
  logic [31:0] redirect_pc;

  logic        imem_req2, imem_ack2, inst_valid2, halted2;
  logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pc2;
  logic        inst_ready2 = 1'b1;
  logic        redirect2   = 1'b0;
  logic        halt2       = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;

  inst_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .inst(inst2), .inst_pc(inst_pc2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .halt(halt2), .halted(halted2)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory for dut: acks mem_lat cycles after the request is first seen; checks bus hold.
  int          mem_lat = 1;
  logic        pend = 1'b0;
  int          wcnt = 0;
  logic [31:0] paddr = 32'h0;
  initial begin
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (pend && wcnt == 1) begin
        imem_ack = 1'b1;
        imem_rdata = word_of(paddr);
      end else begin
        imem_ack = 1'b0;
      end
      if (pend && wcnt > 0) wcnt--;
      #4;
      if (reset) begin
        pend = 1'b0;
      end else if (pend) begin
        chk("bus_hold_req", imem_req, 1);
        chk("bus_hold_addr", imem_addr, paddr);
        if (imem_ack) pend = 1'b0;
      end else if (imem_req) begin
        pend = 1'b1;
        paddr = imem_addr;
        wcnt = mem_lat;
      end
    end
  end

  // Memory for dut2: fixed 1-cycle ack, logs request addresses since last reset.
  logic        pend2 = 1'b0;
  logic [31:0] paddr2 = 32'h0;
  logic [31:0] log2[$];
  initial begin
    imem_ack2 = 1'b0;
    imem_rdata2 = 32'h0;
    forever begin
      @(negedge clk);
      imem_ack2 = pend2;
      imem_rdata2 = word_of(paddr2);
      #4;
      if (reset) begin
        pend2 = 1'b0;
        log2.delete();
      end else if (pend2) begin
        if (imem_ack2) pend2 = 1'b0;
      end else if (imem_req2) begin
        pend2 = 1'b1;
        paddr2 = imem_addr2;
        log2.push_back(imem_addr2);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    halt = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic        cko;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic vld, input logic cko,
                              input logic [31:0] ins, input logic [31:0] ipc);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.req = req; r.addr = addr;
    r.vld = vld; r.cko = cko; r.ins = ins; r.ipc = ipc;
    return r;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        tbl[$];
    logic        found, saw_ack, hold;
    logic [31:0] exp_pc, prev_inst, prev_pc;
    logic [31:0] pcs2[$];
    logic [31:0] words2[$];
    int          pops;

    reset = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;

    // Streaming with ready high, then back-pressure filling the queue.
    tbl.push_back(mk(1, 1, 1, 32'h0, 0, 1, 32'h0,  32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h0, 0, 0, 32'h0,  32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h4, 1, 1, 32'hA0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h4, 0, 0, 32'h0,  32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h8, 1, 1, 32'hA1, 32'h4));
    tbl.push_back(mk(0, 1, 1, 32'h8, 0, 0, 32'h0,  32'h0));
    tbl.push_back(mk(0, 1, 1, 32'hC, 1, 1, 32'hA2, 32'h8));
    tbl.push_back(mk(1, 0, 1, 32'h0, 0, 0, 32'h0,  32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h0, 0, 0, 32'h0,  32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h4, 1, 1, 32'hA0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h4, 1, 1, 32'hA0, 32'h0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hA0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h8, 1, 1, 32'hA0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h8, 1, 1, 32'hA1, 32'h4));
    tbl.push_back(mk(0, 1, 1, 32'hC, 1, 1, 32'hA2, 32'h8));

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      @(negedge clk);
      inst_ready = tbl[k].rdy;
      #4;
      chk($sformatf("vec%0d_req", k), imem_req, tbl[k].req);
      if (tbl[k].req) chk($sformatf("vec%0d_addr", k), imem_addr, tbl[k].addr);
      chk($sformatf("vec%0d_valid", k), inst_valid, tbl[k].vld);
      if (tbl[k].cko) begin
        chk($sformatf("vec%0d_inst", k), inst, tbl[k].ins);
        chk($sformatf("vec%0d_pc", k), inst_pc, tbl[k].ipc);
      end
      chk($sformatf("vec%0d_halted", k), halted, 0);
    end

    // Redirect to 0x103 while the 0xC fetch is outstanding with a 3-cycle ack.
    do_reset();
    inst_ready = 1'b1;
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #4;
      if (imem_ack && imem_addr == 32'h8) mem_lat = 3;
      if (imem_req && imem_addr == 32'hC) found = 1'b1;
    end
    chk("redir_setup", found, 1);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h103;
    #4;
    chk("redir_valid_now", inst_valid, 0);
    found = 1'b0; saw_ack = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      #4;
      if (imem_req && imem_addr == 32'hC) begin
        if (imem_ack) saw_ack = 1'b1;
      end else begin
        found = 1'b1;
      end
      chk("redir_no_stale", inst_valid, 0);
    end
    chk("redir_drain_ack", saw_ack, 1);
    chk("redir_new_req", imem_req, 1);
    chk("redir_new_addr", imem_addr, 32'h100);
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #4;
      if (inst_valid) found = 1'b1;
    end
    chk("redir_first_valid", found, 1);
    chk("redir_first_pc", inst_pc, 32'h100);
    chk("redir_first_inst", inst, word_of(32'h100));

    // Redirect coinciding with a pop and an ack.
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    @(negedge clk);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    #4;
    chk("rpa_ack_present", imem_ack, 1);
    chk("rpa_valid_present", inst_valid, 1);
    @(negedge clk);
    redirect = 1'b0;
    #4;
    chk("rpa_queue_empty", inst_valid, 0);
    chk("rpa_req", imem_req, 1);
    chk("rpa_addr", imem_addr, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #4;
      if (inst_valid) found = 1'b1;
    end
    chk("rpa_valid", found, 1);
    chk("rpa_pc", inst_pc, 32'h200);
    chk("rpa_inst", inst, word_of(32'h200));

    // Address wrap on the second instance.
    do_reset();
    for (int i = 0; i < 20 && pcs2.size() < 3; i++) begin
      @(negedge clk); #4;
      if (inst_valid2) begin
        pcs2.push_back(inst_pc2);
        words2.push_back(inst2);
      end
    end
    chk("wrap_pop_count", pcs2.size(), 3);
    chk("wrap_req_count", (log2.size() >= 3), 1);
    if (pcs2.size() == 3 && log2.size() >= 3) begin
      chk("wrap_req0", log2[0], 32'hFFFF_FFF8);
      chk("wrap_req1", log2[1], 32'hFFFF_FFFC);
      chk("wrap_req2", log2[2], 32'h0000_0000);
      chk("wrap_pc0", pcs2[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", pcs2[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", pcs2[2], 32'h0000_0000);
      chk("wrap_inst2", words2[2], word_of(32'h0));
    end

    // Halt plus redirect with a request outstanding.
    do_reset();
    inst_ready = 1'b1;
    mem_lat = 3;
    @(negedge clk); #4;
    chk("halt_req0", imem_req, 1);
    chk("halt_addr0", imem_addr, 32'h0);
    @(negedge clk);
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    #4;
    chk("halt_not_yet", halted, 0);
    @(negedge clk);
    halt = 1'b0; redirect = 1'b0;
    #4;
    chk("halt_drain_valid", inst_valid, 0);
    @(negedge clk); #4;
    chk("halt_drain_ack", imem_ack, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inst_ready = 1'($urandom_range(0, 1));
      redirect = 1'($urandom_range(0, 1));
      redirect_pc = $urandom;
      #4;
      chk("halt_sticky", halted, 1);
      chk("halt_no_req", imem_req, 0);
      chk("halt_no_valid", inst_valid, 0);
    end
    mem_lat = 1;
    do_reset();
    @(negedge clk); #4;
    chk("halt_reset_clear", halted, 0);
    chk("halt_reset_req", imem_req, 1);
    chk("halt_reset_addr", imem_addr, 32'h0);

    // Randomized traffic against the stream model: every consumed word is the next
    // sequential address since the last reset/redirect, holding while stalled.
    do_reset();
    exp_pc = 32'h0;
    pops = 0;
    hold = 1'b0;
    prev_inst = 32'h0;
    prev_pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mem_lat = $urandom_range(1, 3);
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      #4;
      if (hold) begin
        chk("rand_hold_valid", inst_valid, 1);
        chk("rand_hold_inst", inst, prev_inst);
        chk("rand_hold_pc", inst_pc, prev_pc);
      end
      if (inst_valid && inst_ready) begin
        chk("rand_pc", inst_pc, exp_pc);
        chk("rand_inst", inst, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      hold = inst_valid && !inst_ready && !redirect;
      prev_inst = inst;
      prev_pc = inst_pc;
      if (redirect) exp_pc = redirect_pc & ~32'd3;
    end
    chk("rand_progress", (pops > 200), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
